// File: rtl/vec_seq_pkg.sv
// Shared types and helpers for the vector load/store sequencer.
package vec_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int WORD_BYTES = 4;

    // Lane-index width; a single-lane build still gets a 1-bit index.
    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vec_beat_counter.sv
// Beat index for a vector transfer: shared by address generation and lane select.
module vec_beat_counter
    import vec_seq_pkg::*;
#(
    parameter int LANES = 4,
    parameter int BW    = lane_w(LANES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [BW-1:0] beat_o,
    output logic          last_o
);

    logic [BW-1:0] beat_q, beat_d;

    assign last_o = (beat_q == BW'(LANES - 1));
    assign beat_o = beat_q;

    always_comb begin
        beat_d = beat_q;
        if (clr_i)
            beat_d = '0;
        else if (en_i)
            beat_d = last_o ? '0 : beat_q + BW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            beat_q <= '0;
        else
            beat_q <= beat_d;
    end

endmodule

// File: rtl/vec_mem_sequencer.sv
// Sequences a WORD_W*LANES vector load/store as LANES word beats on the data-memory port.
module vec_mem_sequencer
    import vec_seq_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int LANES  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_load,
    input  logic                      start_store,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [WORD_W*LANES-1:0]   store_data,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WORD_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic [WORD_W-1:0]         mem_rdata,
    output logic [WORD_W*LANES-1:0]   vec_rdata,
    output logic                      vec_wr_en,
    output logic                      stall,
    output logic                      busy,
    output logic                      done
);

    localparam int BW    = lane_w(LANES);
    localparam int SHIFT = $clog2(WORD_BYTES);

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         base_q;
    logic [WORD_W*LANES-1:0]   sdata_q;
    logic [WORD_W*LANES-1:0]   vec_q;
    logic                      ld_q;
    logic [BW-1:0]             beat;
    logic                      last;
    logic                      xfer, beat_done, go_load, go_store;
    int                        lane_lsb;

    assign xfer      = (state_q == S_LOAD) || (state_q == S_STORE);
    assign beat_done = xfer && mem_ready;
    assign go_load   = (state_q == S_IDLE) && start_load;
    // Load has priority when the decoder presents both.
    assign go_store  = (state_q == S_IDLE) && start_store && !start_load;
    assign lane_lsb  = int'(beat) * WORD_W;

    vec_beat_counter #(.LANES(LANES), .BW(BW)) u_beat (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (go_load || go_store),
        .en_i   (beat_done),
        .beat_o (beat),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_load) state_d = S_LOAD;
                     else if (go_store) state_d = S_STORE;
            S_LOAD,
            S_STORE: if (beat_done && last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Beat outputs are forced to zero outside a transfer so reset clears them at once.
    always_comb begin
        mem_req   = xfer;
        mem_we    = (state_q == S_STORE);
        mem_addr  = '0;
        mem_wdata = '0;
        if (xfer) begin
            mem_addr  = base_q + (ADDR_W'(beat) << SHIFT);
            mem_wdata = sdata_q[lane_lsb +: WORD_W];
        end
        done      = (state_q == S_DONE);
        vec_wr_en = (state_q == S_DONE) && ld_q;
        busy      = (state_q != S_IDLE);
        stall     = xfer || ((state_q == S_IDLE) && (start_load || start_store));
        vec_rdata = vec_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            sdata_q <= '0;
            vec_q   <= '0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (go_load || go_store) begin
                base_q <= base_addr & ~ADDR_W'(WORD_BYTES - 1);
                ld_q   <= go_load;
            end
            if (go_store)
                sdata_q <= store_data;
            if (go_load)
                vec_q <= '0;
            else if (beat_done && (state_q == S_LOAD))
                vec_q[lane_lsb +: WORD_W] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench: memory responder plus a word-addressed reference memory model.
module tb_vec_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_load, start_store;
    logic [31:0]  base_addr;
    logic [127:0] store_data;
    logic         mem_req, mem_we, mem_ready;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [127:0] vec_rdata;
    logic         vec_wr_en, stall, busy, done;

    int errors = 0;
    int checks = 0;

    vec_mem_sequencer #(.WORD_W(32), .LANES(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_store(start_store),
        .base_addr(base_addr), .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .vec_rdata(vec_rdata), .vec_wr_en(vec_wr_en), .stall(stall), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // mem: what the responder holds (written by observed beats); ref_mem: what the spec says memory holds.
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    logic [31:0] q_addr[$], q_wd[$];
    bit          q_we[$];
    int          q_done[$], q_wr[$];
    bit          stall_v[64], req_v[64];
    logic [31:0] addr_v[64];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
        return {base[31:2], 2'b00} + 32'(4 * i);
    endfunction

    function automatic logic [127:0] ref_vec(input logic [31:0] base);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = ref_rd(exp_addr(base, i));
        return v;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    // Drives one op (start in cycle 0) and records what the port did for ncyc cycles.
    task automatic do_op(input bit ld, input bit st, input logic [31:0] base, input logic [127:0] sd,
                         input int w[4], input int ncyc, input bit hold);
        int b, wl;
        b = 0; wl = w[0];
        q_addr.delete(); q_wd.delete(); q_we.delete(); q_done.delete(); q_wr.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                start_load = ld; start_store = st; base_addr = base; store_data = sd;
            end else if (!hold) begin
                start_load = 0; start_store = 0;
            end
            if (mem_req && b < 4 && wl > 0) begin
                mem_ready = 0; wl--;
            end else mem_ready = 1;
            mem_rdata = rd(mem_addr);
            @(negedge clk);
            stall_v[c] = stall; req_v[c] = mem_req; addr_v[c] = mem_addr;
            if (mem_req && mem_ready) begin
                q_addr.push_back(mem_addr); q_wd.push_back(mem_wdata); q_we.push_back(mem_we);
                if (mem_we) mem[mem_addr] = mem_wdata;
                b++;
                if (b < 4) wl = w[b];
            end
            if (done) q_done.push_back(c);
            if (vec_wr_en) q_wr.push_back(c);
        end
        start_load = 0; start_store = 0; mem_ready = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        checks++; if (mem_req !== 0 || busy !== 0 || done !== 0 || vec_wr_en !== 0) begin errors++;
            $display("FAIL reset_ctrl: req=%b busy=%b done=%b wr=%b want all 0", mem_req, busy, done, vec_wr_en); end
        checks++; if (mem_addr !== 0 || mem_wdata !== 0 || vec_rdata !== 0 || mem_we !== 0) begin errors++;
            $display("FAIL reset_data: addr=%h wdata=%h vec=%h we=%b want 0", mem_addr, mem_wdata, vec_rdata, mem_we); end
        checks++; if (stall !== 0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_load_basic();
        logic [127:0] exp;
        preload(32'h100, 32'h11111111); preload(32'h104, 32'h22222222);
        preload(32'h108, 32'h33333333); preload(32'h10C, 32'h44444444);
        do_op(1, 0, 32'h100, '0, '{0, 0, 0, 0}, 7, 0);
        checks++; if (q_addr.size() !== 4) begin errors++; $display("FAIL load_beats: got %0d want 4", q_addr.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (q_addr[i] !== exp_addr(32'h100, i) || q_we[i] !== 0) begin errors++;
                $display("FAIL load_addr%0d: got %h we=%b want %h we=0", i, q_addr[i], q_we[i], exp_addr(32'h100, i)); end
        end
        for (int c = 1; c <= 4; c++) begin
            checks++; if (!req_v[c] || addr_v[c] !== 32'h100 + 32'(4 * (c - 1))) begin errors++;
                $display("FAIL load_cycle%0d: req=%b addr=%h", c, req_v[c], addr_v[c]); end
        end
        checks++; if (q_done.size() !== 1 || q_done[0] !== 5) begin errors++;
            $display("FAIL load_done: cnt=%0d cyc=%0d want 1 at 5", q_done.size(), q_done.size() ? q_done[0] : -1); end
        checks++; if (q_wr.size() !== 1 || q_wr[0] !== 5) begin errors++;
            $display("FAIL load_wren: cnt=%0d want 1 at cycle 5", q_wr.size()); end
        checks++; if ({stall_v[6], stall_v[5], stall_v[4], stall_v[3], stall_v[2], stall_v[1], stall_v[0]} !== 7'b0011111) begin errors++;
            $display("FAIL load_stall: got %b%b%b%b%b%b%b want 0011111", stall_v[6], stall_v[5], stall_v[4], stall_v[3], stall_v[2], stall_v[1], stall_v[0]); end
        exp = 128'h44444444_33333333_22222222_11111111;
        checks++; if (vec_rdata !== exp) begin errors++; $display("FAIL load_vec: got %h want %h", vec_rdata, exp); end
    endtask

    task automatic test_store();
        logic [127:0] sd;
        logic [31:0]  wexp[4];
        sd = 128'hDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666;
        wexp = '{32'h77776666, 32'h99998888, 32'hBBBBAAAA, 32'hDDDDCCCC};
        do_op(0, 1, 32'h203, sd, '{0, 0, 0, 0}, 7, 0);
        for (int i = 0; i < 4; i++) ref_mem[32'h200 + 32'(4 * i)] = wexp[i];
        checks++; if (q_addr.size() !== 4) begin errors++; $display("FAIL store_beats: got %0d want 4", q_addr.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (q_addr[i] !== 32'h200 + 32'(4 * i) || q_wd[i] !== wexp[i] || q_we[i] !== 1) begin errors++;
                $display("FAIL store_beat%0d: addr=%h wdata=%h we=%b want %h %h 1", i, q_addr[i], q_wd[i], q_we[i], 32'h200 + 32'(4 * i), wexp[i]); end
        end
        checks++; if (q_wr.size() !== 0) begin errors++; $display("FAIL store_wren: got %0d pulses want 0", q_wr.size()); end
        checks++; if (q_done.size() !== 1 || q_done[0] !== 5) begin errors++; $display("FAIL store_done: cnt=%0d want 1 at 5", q_done.size()); end
    endtask

    task automatic test_wait_states();
        int hold;
        hold = 0;
        do_op(1, 0, 32'h100, '0, '{0, 3, 0, 0}, 10, 0);
        for (int c = 0; c < 10; c++) if (req_v[c] && addr_v[c] == 32'h104) hold++;
        checks++; if (hold !== 4) begin errors++; $display("FAIL wait_hold: addr 0x104 for %0d cycles want 4", hold); end
        checks++; if (q_done.size() !== 1 || q_done[0] !== 8) begin errors++;
            $display("FAIL wait_done: cnt=%0d cyc=%0d want 8", q_done.size(), q_done.size() ? q_done[0] : -1); end
        checks++; if (vec_rdata !== ref_vec(32'h100)) begin errors++; $display("FAIL wait_vec: got %h want %h", vec_rdata, ref_vec(32'h100)); end
    endtask

    task automatic test_both_starts();
        int nwe;
        nwe = 0;
        do_op(1, 1, 32'h400, {$urandom, $urandom, $urandom, $urandom}, '{0, 0, 0, 0}, 7, 0);
        foreach (q_we[i]) if (q_we[i]) nwe++;
        checks++; if (q_addr.size() !== 4 || nwe !== 0) begin errors++; $display("FAIL both_we: beats=%0d writes=%0d want 4 0", q_addr.size(), nwe); end
        checks++; if (vec_rdata !== ref_vec(32'h400) || q_wr.size() !== 1) begin errors++;
            $display("FAIL both_vec: got %h wr=%0d want %h wr=1", vec_rdata, q_wr.size(), ref_vec(32'h400)); end
        checks++; if (mem.exists(32'h400)) begin errors++; $display("FAIL both_nowrite: 0x400 written with %h want untouched", mem[32'h400]); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        start_load = 1; base_addr = 32'h300; mem_ready = 1; mem_rdata = rd(mem_addr);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            start_load = 0; mem_rdata = rd(mem_addr);
        end
        checks++; if (mem_req !== 1 || mem_addr !== 32'h308) begin errors++;
            $display("FAIL rstmid_pre: req=%b addr=%h want 1 308", mem_req, mem_addr); end
        rst_n = 0; #1;
        checks++; if (mem_req !== 0 || busy !== 0 || vec_rdata !== 0 || mem_addr !== 0) begin errors++;
            $display("FAIL rstmid_now: req=%b busy=%b vec=%h addr=%h want 0", mem_req, busy, vec_rdata, mem_addr); end
        @(posedge clk); #1 rst_n = 1;
        do_op(1, 0, 32'h300, '0, '{0, 0, 0, 0}, 7, 0);
        checks++; if (vec_rdata !== ref_vec(32'h300) || q_done.size() !== 1 || q_done[0] !== 5) begin errors++;
            $display("FAIL rstmid_after: vec=%h done=%0d want %h at 5", vec_rdata, q_done.size(), ref_vec(32'h300)); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp[4];
        exp = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
        do_op(1, 0, 32'hFFFFFFF8, '0, '{0, 0, 0, 0}, 7, 0);
        checks++; if (q_addr.size() !== 4) begin errors++; $display("FAIL wrap_beats: got %0d want 4", q_addr.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (q_addr[i] !== exp[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, q_addr[i], exp[i]); end
        end
        checks++; if (vec_rdata !== ref_vec(32'hFFFFFFF8)) begin errors++; $display("FAIL wrap_vec: got %h want %h", vec_rdata, ref_vec(32'hFFFFFFF8)); end
    endtask

    task automatic test_back_to_back();
        do_op(1, 0, 32'h500, '0, '{0, 0, 0, 0}, 13, 1);
        checks++; if (q_done.size() !== 2 || q_done[0] !== 5 || q_done[1] !== 11) begin errors++;
            $display("FAIL b2b_done: cnt=%0d want pulses at 5 and 11", q_done.size()); end
        checks++; if (stall_v[5] !== 0 || stall_v[6] !== 1 || q_addr.size() !== 8) begin errors++;
            $display("FAIL b2b_stall: s5=%b s6=%b beats=%0d want 0 1 8", stall_v[5], stall_v[6], q_addr.size()); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            bit ld, st;
            logic [31:0]  base;
            logic [127:0] sd, expv;
            int w[4];
            int sumw;
            ld = $urandom_range(0, 1); st = ld ? $urandom_range(0, 1) : 1;
            base = $urandom; sd = {$urandom, $urandom, $urandom, $urandom};
            sumw = 0;
            for (int i = 0; i < 4; i++) begin w[i] = $urandom_range(0, 2); sumw += w[i]; end
            expv = ref_vec(base);
            do_op(ld, st, base, sd, w, 7 + sumw, 0);
            if (!ld) for (int i = 0; i < 4; i++) ref_mem[exp_addr(base, i)] = sd[i*32 +: 32];
            checks++; if (q_addr.size() !== 4) begin errors++; $display("FAIL rnd%0d_beats: got %0d want 4", n, q_addr.size()); end
            else for (int i = 0; i < 4; i++) begin
                checks++; if (q_addr[i] !== exp_addr(base, i) || q_we[i] !== !ld || (!ld && q_wd[i] !== sd[i*32 +: 32])) begin errors++;
                    $display("FAIL rnd%0d_beat%0d: addr=%h we=%b wd=%h want %h %b %h", n, i, q_addr[i], q_we[i], q_wd[i], exp_addr(base, i), !ld, sd[i*32 +: 32]); end
            end
            checks++; if (q_done.size() !== 1 || q_done[0] !== 5 + sumw || q_wr.size() !== int'(ld)) begin errors++;
                $display("FAIL rnd%0d_done: cnt=%0d cyc=%0d wr=%0d want cyc %0d wr %0d", n, q_done.size(), q_done.size() ? q_done[0] : -1, q_wr.size(), 5 + sumw, ld); end
            if (ld) begin
                checks++; if (vec_rdata !== expv) begin errors++; $display("FAIL rnd%0d_vec: got %h want %h", n, vec_rdata, expv); end
            end
        end
    endtask

    initial begin
        start_load = 0; start_store = 0; base_addr = 0; store_data = 0;
        mem_ready = 1; mem_rdata = 0;
        test_reset();
        test_load_basic();
        test_store();
        test_wait_states();
        test_both_starts();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
Multi-cycle sequencer for the SIMD datapath's 128-bit vector load/store instructions (AES state moves) over the 32-bit data-memory port. The instruction decoder raises start_load/start_store. The block issues LANES word beats with a req/ready handshake and stalls the pipeline meanwhile. For loads it assembles the vector and pulses a vector-register-file write.

Parameters:
WORD_W, 32, memory word width in bits
LANES, 4, words per vector (vector width = WORD_W*LANES)
ADDR_W, 32, byte-address width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start_load  in  1  decoded vector-load instruction present
start_store  in  1  decoded vector-store instruction present
base_addr  in  ADDR_W  vector byte base address; bits [1:0] ignored
store_data  in  WORD_W*LANES  vector to store; lane i = bits [i*WORD_W +: WORD_W]
mem_req  out  1  beat request
mem_we  out  1  beat is a write
mem_addr  out  ADDR_W  beat word address
mem_wdata  out  WORD_W  beat write data
mem_ready  in  1  memory accepts/completes beat this cycle
mem_rdata  in  WORD_W  read data, valid when mem_req && mem_ready && !mem_we
vec_rdata  out  WORD_W*LANES  assembled load vector
vec_wr_en  out  1  one-cycle vector register write strobe
stall  out  1  freeze fetch/decode
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (asynchronous, any state, mid-transfer included): state=IDLE, beat=0.
  - Outputs zero: mem_req, mem_we, mem_addr, mem_wdata, vec_rdata, vec_wr_en, done, busy.
  - mem_req drops immediately. A partial load is discarded. A partial store leaves earlier beats written.
- States: IDLE, LOAD, STORE, DONE.
- IDLE:
  - start_load=1 -> LOAD. start_store=1 (load low) -> STORE.
  - Both high: load wins and the store is ignored.
  - On entry, latch {base_addr[ADDR_W-1:2],2'b00}. STORE also latches store_data.
  - Set beat=0 and clear vec_rdata.
- LOAD/STORE:
  - mem_req=1. mem_we=1 only in STORE.
  - mem_addr = latched base + 4*beat, modulo 2^ADDR_W (wraps at top of address space).
  - mem_wdata = latched lane[beat].
  - Beat completes in a cycle with mem_req && mem_ready. mem_addr, mem_wdata and mem_we stay stable until then.
  - LOAD: on completion, write mem_rdata into vec_rdata lane[beat].
  - Completion with beat==LANES-1 -> DONE. Otherwise beat+1.
  - mem_ready while mem_req=0 is ignored.
- DONE (exactly one cycle):
  - done=1. vec_wr_en=1 only if the op was a load. mem_req=0.
  - start inputs are ignored. Always -> IDLE.
- vec_rdata holds its value until the next load start.
- stall (combinational) = (state==LOAD || state==STORE) || (state==IDLE && (start_load||start_store)).
  - stall=0 in DONE, so the instruction retires at the DONE->IDLE edge.
- Latency with mem_ready tied high: start seen in cycle 0, beats in cycles 1..LANES, DONE in cycle LANES+1.
  - Stall spans LANES+1 cycles.
- Each wait cycle (mem_ready=0) adds one cycle.
- Back-to-back ops: a new start is accepted in the IDLE cycle after DONE.

Decomposition:
- Package vec_seq_pkg holds:
  - state enum (IDLE, LOAD, STORE, DONE)
  - WORD_BYTES=4 constant
  - the lane-index width function clog2(LANES)
- One natural sub-module: vec_beat_counter.
  - Beat index with clear, enable and a last flag (beat==LANES-1).
  - Used for both address generation and lane select.

Test Plan:
- Load, base=0x100, mem_ready=1, rdata per beat 0x11111111/0x22222222/0x33333333/0x44444444.
  -> addrs 0x100,0x104,0x108,0x10C in cycles 1-4.
  -> DONE in cycle 5 with vec_wr_en=1, done=1.
  -> vec_rdata=0x44444444_33333333_22222222_11111111.
  -> stall high in cycles 0-4 only.
- Store, base=0x203, store_data=0xDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666 (lane 0 = 0x77776666).
  -> mem_we=1, addrs 0x200..0x20C.
  -> wdata 0x77776666, 0x99998888, 0xBBBBAAAA, 0xDDDDCCCC.
  -> vec_wr_en stays 0, done pulses once.
- Load, mem_ready low 3 cycles on beat 1.
  -> mem_addr holds 0x104 for 4 cycles, DONE in cycle 8, data correct.
- start_load and start_store asserted together -> load performed (mem_we=0 on every beat), store dropped.
- rst_n low during beat 2 of a load -> same cycle: mem_req=0, busy=0, vec_rdata=0. After release, a new load completes normally.
- Load with base=0xFFFFFFF8 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
